// File: rtl/data_mem_responder_if.sv
// Store/load/preload bus between the core (or loader) and the data-memory responder.
//
// Handshake semantics: there is no ready/backpressure on the request side. A request
// (i_*_enable high) is accepted or dropped on the rising edge it is sampled on. Acceptance
// is possible only while o_ready is high. A dropped request produces a one-cycle o_err
// pulse in the following cycle. A load sampled at edge E produces o_load_valid for
// exactly the cycle after E.
interface data_mem_responder_if #(
    parameter int REG_WIDTH  = 32,
    parameter int NUM_MEM    = 5,
    parameter int MEM_SELECT = $clog2(NUM_MEM)
);
    logic                          i_store_enable;
    logic [MEM_SELECT-1:0]         i_store_select;
    logic [REG_WIDTH-1:0]          i_store_word;
    logic                          i_load_enable;
    logic [MEM_SELECT-1:0]         i_load_select;
    logic                          o_load_valid;
    logic [REG_WIDTH-1:0]          o_load_word;
    logic                          i_preload_enable;
    logic [MEM_SELECT-1:0]         i_preload_select;
    logic [REG_WIDTH-1:0]          i_preload_word;
    logic                          o_ready;
    logic                          o_err;
    logic [NUM_MEM*REG_WIDTH-1:0]  o_mem;
    logic                          state_dbg;

    modport master (
        output i_store_enable, i_store_select, i_store_word,
        output i_load_enable, i_load_select,
        output i_preload_enable, i_preload_select, i_preload_word,
        input  o_load_valid, o_load_word, o_ready, o_err, o_mem, state_dbg
    );

    modport slave (
        input  i_store_enable, i_store_select, i_store_word,
        input  i_load_enable, i_load_select,
        input  i_preload_enable, i_preload_select, i_preload_word,
        output o_load_valid, o_load_word, o_ready, o_err, o_mem, state_dbg
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: memory side of the core's store/load interface.
// Clears the array after reset, commits core stores through a STORE_LAT-deep
// pipeline with load forwarding, and accepts loader preloads once ready.
// Loads arriving during the clear sweep are dropped without a load response.
module data_mem_responder #(
    parameter int REG_WIDTH  = 32,
    parameter int NUM_MEM    = 5,
    parameter int MEM_SELECT = $clog2(NUM_MEM),
    parameter int STORE_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus
);
    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    // With STORE_LAT=1 the delay line is unused; keep one dummy entry held empty.
    localparam int DL_N = (STORE_LAT > 1) ? STORE_LAT - 1 : 1;
    localparam logic [MEM_SELECT-1:0] LAST_PTR  = MEM_SELECT'(NUM_MEM - 1);
    localparam logic [MEM_SELECT:0]   NUM_MEM_W = (MEM_SELECT + 1)'(NUM_MEM);

    state_t                 state_q, state_d;
    logic [MEM_SELECT-1:0]  ptr_q, ptr_d;
    logic [REG_WIDTH-1:0]   mem [NUM_MEM];

    logic                   dl_v    [DL_N];
    logic [MEM_SELECT-1:0]  dl_sel  [DL_N];
    logic [REG_WIDTH-1:0]   dl_word [DL_N];

    logic                   ready;
    logic                   st_in, ld_in, pl_in;
    logic                   st_ok, ld_ok, pl_ok;
    logic                   commit_v;
    logic [MEM_SELECT-1:0]  commit_sel;
    logic [REG_WIDTH-1:0]   commit_word;
    logic                   collide;
    logic                   err_d;
    logic [REG_WIDTH-1:0]   fwd_word;

    assign ready = (state_q == READY);
    assign st_in = ({1'b0, bus.i_store_select}   < NUM_MEM_W);
    assign ld_in = ({1'b0, bus.i_load_select}    < NUM_MEM_W);
    assign pl_in = ({1'b0, bus.i_preload_select} < NUM_MEM_W);
    assign st_ok = ready && bus.i_store_enable   && st_in;
    assign ld_ok = ready && bus.i_load_enable    && ld_in;
    assign pl_ok = ready && bus.i_preload_enable && pl_in;

    // FSM state register and sweep pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: sweep every word once, then stay READY until reset.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            CLEAR: begin
                if (ptr_q == LAST_PTR) begin
                    state_d = READY;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + MEM_SELECT'(1);
                end
            end
            READY:   state_d = READY;
            default: state_d = CLEAR;
        endcase
    end

    // Store reaching the array this edge: the incoming store, or the oldest delay entry.
    always_comb begin
        if (STORE_LAT == 1) begin
            commit_v    = st_ok;
            commit_sel  = bus.i_store_select;
            commit_word = bus.i_store_word;
        end else begin
            commit_v    = dl_v[DL_N-1];
            commit_sel  = dl_sel[DL_N-1];
            commit_word = dl_word[DL_N-1];
        end
    end

    assign collide = pl_ok && commit_v && (commit_sel == bus.i_preload_select);

    // Any dropped request, or a preload losing to a store commit.
    assign err_d = (!ready && (bus.i_store_enable || bus.i_load_enable || bus.i_preload_enable))
                || (ready && ((bus.i_store_enable && !st_in) || (bus.i_load_enable && !ld_in)
                           || (bus.i_preload_enable && !pl_in) || collide));

    // Load forwarding: array, then delay line oldest-to-youngest, then same-cycle store.
    always_comb begin
        fwd_word = '0;
        for (int k = 0; k < NUM_MEM; k++) begin
            if (bus.i_load_select == MEM_SELECT'(k)) fwd_word = mem[k];
        end
        for (int j = DL_N - 1; j >= 0; j--) begin
            if (dl_v[j] && (dl_sel[j] == bus.i_load_select)) fwd_word = dl_word[j];
        end
        if (st_ok && (bus.i_store_select == bus.i_load_select)) fwd_word = bus.i_store_word;
    end

    // Store delay line; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DL_N; j++) begin
                dl_v[j]    <= 1'b0;
                dl_sel[j]  <= '0;
                dl_word[j] <= '0;
            end
        end else begin
            dl_v[0]    <= (STORE_LAT > 1) && st_ok;
            dl_sel[0]  <= bus.i_store_select;
            dl_word[0] <= bus.i_store_word;
            for (int j = 1; j < DL_N; j++) begin
                dl_v[j]    <= dl_v[j-1];
                dl_sel[j]  <= dl_sel[j-1];
                dl_word[j] <= dl_word[j-1];
            end
        end
    end

    // Array write port: sweep zeroes in CLEAR; store commit beats preload in READY.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_MEM; k++) begin
            if (state_q == CLEAR) begin
                if (ptr_q == MEM_SELECT'(k)) mem[k] <= '0;
            end else if (commit_v && (commit_sel == MEM_SELECT'(k))) begin
                mem[k] <= commit_word;
            end else if (pl_ok && (bus.i_preload_select == MEM_SELECT'(k))) begin
                mem[k] <= bus.i_preload_word;
            end
        end
    end

    // Registered load response and error pulse; out-of-range loads return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.o_load_valid <= 1'b0;
            bus.o_load_word  <= '0;
            bus.o_err        <= 1'b0;
        end else begin
            bus.o_load_valid <= ready && bus.i_load_enable;
            bus.o_load_word  <= ld_ok ? fwd_word : '0;
            bus.o_err        <= err_d;
        end
    end

    // Snapshot bus: committed array contents, forced to zero until the sweep ends.
    always_comb begin
        bus.o_mem = '0;
        for (int k = 0; k < NUM_MEM; k++) begin
            bus.o_mem[k*REG_WIDTH +: REG_WIDTH] = ready ? mem[k] : '0;
        end
    end

    assign bus.o_ready   = ready;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: four instances (STORE_LAT 1..4) share one stimulus
// stream; a transaction-level model predicts every instance's outputs each cycle.
module tb_data_mem_responder;
    localparam int NI = 4;
    localparam int NM = 5;
    localparam int RW = 32;
    localparam int MS = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared stimulus ----------------
    logic          st_en = 0, ld_en = 0, pl_en = 0;
    logic [MS-1:0] st_sel = 0, ld_sel = 0, pl_sel = 0;
    logic [RW-1:0] st_w = 0, pl_w = 0;

    logic          dut_ready [NI];
    logic          dut_err   [NI];
    logic          dut_lv    [NI];
    logic [RW-1:0] dut_lw    [NI];
    logic [NM*RW-1:0] dut_mem [NI];
    logic          dut_state [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        data_mem_responder_if #(.REG_WIDTH(RW), .NUM_MEM(NM)) bus ();
        assign bus.i_store_enable   = st_en;
        assign bus.i_store_select   = st_sel;
        assign bus.i_store_word     = st_w;
        assign bus.i_load_enable    = ld_en;
        assign bus.i_load_select    = ld_sel;
        assign bus.i_preload_enable = pl_en;
        assign bus.i_preload_select = pl_sel;
        assign bus.i_preload_word   = pl_w;
        data_mem_responder #(.REG_WIDTH(RW), .NUM_MEM(NM), .STORE_LAT(g + 1)) dut (
            .clk(clk), .rst_n(rst_n), .bus(bus)
        );
        assign dut_ready[g] = bus.o_ready;
        assign dut_err[g]   = bus.o_err;
        assign dut_lv[g]    = bus.o_load_valid;
        assign dut_lw[g]    = bus.o_load_word;
        assign dut_mem[g]   = bus.o_mem;
        assign dut_state[g] = bus.state_dbg;
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0]    inst;
        logic [MS-1:0] sel;
        logic [RW-1:0] word;
        int            due;
    } pend_t;

    pend_t         pend_q[$];
    logic [RW-1:0] m_mem [NI][NM];
    int            rel_edges = 0;
    int            edge_n = 0;
    logic          e_ready [NI];
    logic          e_err   [NI];
    logic          e_lv    [NI];
    logic [RW-1:0] e_lw    [NI];

    int checks = 0;
    int errors = 0;

    function automatic logic [NM*RW-1:0] pack_mem(int i);
        logic [NM*RW-1:0] r;
        r = '0;
        if (rel_edges >= NM)
            for (int k = 0; k < NM; k++) r[k*RW +: RW] = m_mem[i][k];
        return r;
    endfunction

    task automatic model_reset();
        pend_q.delete();
        rel_edges = 0;
        for (int i = 0; i < NI; i++) begin
            e_ready[i] = 0; e_err[i] = 0; e_lv[i] = 0; e_lw[i] = '0;
        end
    endtask

    // Effect of the coming rising edge, from the current inputs.
    task automatic model_edge();
        logic          rdy;
        logic [RW-1:0] v;
        logic          cm_hit;
        edge_n++;
        rdy = (rel_edges >= NM);
        for (int i = 0; i < NI; i++) begin
            e_err[i] = 0; e_lv[i] = 0; e_lw[i] = '0;
            if (!rdy) begin
                if (st_en || ld_en || pl_en) e_err[i] = 1;
                m_mem[i][rel_edges] = '0;
            end else begin
                if (ld_en) begin
                    e_lv[i] = 1;
                    if (ld_sel < NM) begin
                        v = m_mem[i][ld_sel];
                        foreach (pend_q[j])
                            if (pend_q[j].inst == 2'(i) && pend_q[j].sel == ld_sel) v = pend_q[j].word;
                        if (st_en && st_sel == ld_sel) v = st_w;
                        e_lw[i] = v;
                    end else begin
                        e_err[i] = 1;
                    end
                end
                if (st_en) begin
                    if (st_sel < NM) pend_q.push_back('{inst: 2'(i), sel: st_sel, word: st_w, due: edge_n + i});
                    else e_err[i] = 1;
                end
                cm_hit = 0;
                for (int j = 0; j < pend_q.size(); ) begin
                    if (pend_q[j].inst == 2'(i) && pend_q[j].due == edge_n) begin
                        m_mem[i][pend_q[j].sel] = pend_q[j].word;
                        if (pl_en && pl_sel == pend_q[j].sel) cm_hit = 1;
                        pend_q.delete(j);
                    end else begin
                        j++;
                    end
                end
                if (pl_en) begin
                    if (pl_sel >= NM) e_err[i] = 1;
                    else if (cm_hit) e_err[i] = 1;
                    else m_mem[i][pl_sel] = pl_w;
                end
            end
        end
        if (rel_edges < NM) rel_edges++;
        for (int i = 0; i < NI; i++) e_ready[i] = (rel_edges >= NM);
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(string name, logic [NM*RW-1:0] act, logic [NM*RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("ready[lat%0d]", i + 1), dut_ready[i], e_ready[i]);
            chk($sformatf("err[lat%0d]", i + 1), dut_err[i], e_err[i]);
            chk($sformatf("load_valid[lat%0d]", i + 1), dut_lv[i], e_lv[i]);
            if (e_lv[i]) chk($sformatf("load_word[lat%0d]", i + 1), dut_lw[i], e_lw[i]);
            chk($sformatf("mem[lat%0d]", i + 1), dut_mem[i], pack_mem(i));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic se, input logic [MS-1:0] ss, input logic [RW-1:0] sw,
                          input logic le, input logic [MS-1:0] ls,
                          input logic pe, input logic [MS-1:0] ps, input logic [RW-1:0] pw);
        st_en = se; st_sel = ss; st_w = sw;
        ld_en = le; ld_sel = ls;
        pl_en = pe; pl_sel = ps; pl_w = pw;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: model the edge, let the DUT take it, compare on the falling edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        idle();
    endtask

    task automatic do_reset(int cycles);
        idle();
        rst_n = 0;
        model_reset();
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
            compare_all();
        end
        rst_n = 1;
    endtask

    function automatic logic [MS-1:0] rnd_sel();
        return ($urandom_range(0, 99) < 85) ? MS'($urandom_range(0, NM - 1)) : MS'($urandom_range(NM, 7));
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        for (int i = 0; i < NI; i++)
            for (int k = 0; k < NM; k++) m_mem[i][k] = '0;
        @(negedge clk);
        do_reset(2);

        // Clear sweep: ready after exactly NM edges; requests during it are dropped.
        for (int t = 0; t < NM; t++) begin
            if (t == 1) set_in(1, 3'd1, 32'h55, 1, 3'd1, 1, 3'd2, 32'h66);
            tick();
            chk("lit_ready_sweep", dut_ready[0], (t == NM - 1));
            if (t == 1) chk("lit_err_in_clear", dut_err[0], 1'b1);
        end

        // Preload words 0 and 1, then a core store to word 2.
        set_in(0, 0, 0, 0, 0, 1, 3'd0, 32'd1); tick();
        set_in(0, 0, 0, 0, 0, 1, 3'd1, 32'd2); tick();
        set_in(1, 3'd2, 32'd3, 0, 0, 0, 0, 0); tick();
        chk("lit_mem_after_store", dut_mem[0], {32'd0, 32'd0, 32'd3, 32'd2, 32'd1});

        // Store 0xA5 to word 4 with loads in the same and the next two cycles.
        set_in(1, 3'd4, 32'hA5, 1, 3'd4, 0, 0, 0); tick();
        chk("lit_fwd0_lat3", dut_lw[2], 32'hA5);
        chk("lit_word4_lat3_e1", dut_mem[2][4*RW +: RW], 32'h0);
        set_in(0, 0, 0, 1, 3'd4, 0, 0, 0); tick();
        chk("lit_fwd1_lat3", dut_lw[2], 32'hA5);
        chk("lit_word4_lat3_e2", dut_mem[2][4*RW +: RW], 32'h0);
        set_in(0, 0, 0, 1, 3'd4, 0, 0, 0); tick();
        chk("lit_fwd2_lat3", dut_lw[2], 32'hA5);
        chk("lit_word4_lat3_e3", dut_mem[2][4*RW +: RW], 32'hA5);

        // Back-to-back stores to word 1, then a load of it.
        set_in(1, 3'd1, 32'd5, 0, 0, 0, 0, 0); tick();
        set_in(1, 3'd1, 32'd6, 0, 0, 0, 0, 0); tick();
        set_in(1, 3'd1, 32'd7, 0, 0, 0, 0, 0); tick();
        set_in(0, 0, 0, 1, 3'd1, 0, 0, 0); tick();
        chk("lit_b2b_load_lat2", dut_lw[1], 32'd7);
        tick();
        chk("lit_b2b_word1_lat2", dut_mem[1][1*RW +: RW], 32'd7);

        // Out-of-range store and load.
        set_in(1, 3'd6, 32'hDEAD, 0, 0, 0, 0, 0); tick();
        chk("lit_oor_store_err", dut_err[0], 1'b1);
        set_in(0, 0, 0, 1, 3'd7, 0, 0, 0); tick();
        chk("lit_oor_load_valid", dut_lv[0], 1'b1);
        chk("lit_oor_load_word", dut_lw[0], 32'h0);
        chk("lit_oor_load_err", dut_err[0], 1'b1);

        // Preload colliding with a store commit on the same edge: the store wins.
        set_in(1, 3'd3, 32'h33, 0, 0, 1, 3'd3, 32'h99); tick();
        chk("lit_collide_err", dut_err[0], 1'b1);
        chk("lit_collide_word3", dut_mem[0][3*RW +: RW], 32'h33);
        repeat (4) tick();

        // Reset with a store in flight: it must never land.
        set_in(1, 3'd0, 32'h77, 0, 0, 0, 0, 0); tick();
        do_reset(1);
        for (int t = 0; t < NM; t++) begin
            tick();
            chk("lit_ready_resweep", dut_ready[3], (t == NM - 1));
        end
        set_in(0, 0, 0, 1, 3'd0, 0, 0, 0); tick();
        chk("lit_inflight_dropped_load", dut_lw[3], 32'h0);
        chk("lit_inflight_dropped_word0", dut_mem[3][0 +: RW], 32'h0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset($urandom_range(1, 2));
            end else begin
                set_in($urandom_range(0, 1) == 1, rnd_sel(), $urandom,
                       $urandom_range(0, 1) == 1, rnd_sel(),
                       $urandom_range(0, 3) == 0, rnd_sel(), $urandom);
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
